// File: rtl/data_unpad_axis.sv
// Pixel unpadding stage for AXI-Stream video: strips pad bits from every lane
// (optionally byte-reversing the kept pixel), buffers through a 2-entry skid
// buffer and checks line lengths against LINE_BEATS.
module data_unpad_axis #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned PIX_IN_W   = 32,
    parameter int unsigned PIX_OUT_W  = 24,
    parameter int unsigned LINE_BEATS = 480
) (
    input  logic                         I_clk,
    input  logic                         I_rstn,
    input  logic [1:0]                   I_mode,
    input  logic [LANES*PIX_IN_W-1:0]    I_tdata,
    input  logic                         I_tvalid,
    input  logic                         I_tuser,
    input  logic                         I_tlast,
    output logic                         O_tready,
    output logic [LANES*PIX_OUT_W-1:0]   O_tdata,
    output logic                         O_tvalid,
    output logic                         O_tuser,
    output logic                         O_tlast,
    input  logic                         I_tready,
    output logic                         O_err_len,
    output logic [15:0]                  O_frame_cnt
);

    localparam int unsigned OW     = LANES * PIX_OUT_W;
    localparam int unsigned NB     = PIX_OUT_W / 8;
    localparam int unsigned PAD_W  = PIX_IN_W - PIX_OUT_W;
    localparam int unsigned CW     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_BEATS - 1);

    // Head entry drives the outputs directly; skid entry catches the beat
    // accepted while the head is stalled.
    logic [OW-1:0]    head_data_q, head_data_d;
    logic             head_user_q, head_user_d;
    logic             head_last_q, head_last_d;
    logic             head_vld_q,  head_vld_d;
    logic [OW-1:0]    skid_data_q, skid_data_d;
    logic             skid_user_q, skid_user_d;
    logic             skid_last_q, skid_last_d;
    logic             skid_vld_q,  skid_vld_d;
    logic             rdy_q,       rdy_d;
    logic [1:0]       mode_q,      mode_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             err_q,       err_d;
    logic [15:0]      fcnt_q,      fcnt_d;

    logic             push;
    logic             pop;
    logic [1:0]       map_mode;
    logic [OW-1:0]    map_data;
    logic [PIX_OUT_W-1:0] pix;
    logic [PIX_OUT_W-1:0] swp;
    logic [CW-1:0]    idx;

    assign O_tready    = rdy_q;
    assign O_tvalid    = head_vld_q;
    assign O_tdata     = head_data_q;
    assign O_tuser     = head_user_q;
    assign O_tlast     = head_last_q;
    assign O_err_len   = err_q;
    assign O_frame_cnt = fcnt_q;

    assign push = I_tvalid & rdy_q;
    assign pop  = head_vld_q & I_tready;

    // Per-lane unpad; a start-of-frame beat already uses its own I_mode.
    always_comb begin
        map_mode = I_tuser ? I_mode : mode_q;
        map_data = '0;
        pix      = '0;
        swp      = '0;
        for (int k = 0; k < LANES; k++) begin
            if (map_mode[0]) begin
                pix = I_tdata[k*PIX_IN_W + PAD_W +: PIX_OUT_W];
            end else begin
                pix = I_tdata[k*PIX_IN_W +: PIX_OUT_W];
            end
            for (int b = 0; b < NB; b++) begin
                swp[b*8 +: 8] = pix[(NB-1-b)*8 +: 8];
            end
            map_data[k*PIX_OUT_W +: PIX_OUT_W] = map_mode[1] ? swp : pix;
        end
    end

    // Skid buffer next state: refill head from skid first to keep order.
    always_comb begin
        head_data_d = head_data_q;
        head_user_d = head_user_q;
        head_last_d = head_last_q;
        head_vld_d  = head_vld_q;
        skid_data_d = skid_data_q;
        skid_user_d = skid_user_q;
        skid_last_d = skid_last_q;
        skid_vld_d  = skid_vld_q;
        if (pop) begin
            if (skid_vld_q) begin
                head_data_d = skid_data_q;
                head_user_d = skid_user_q;
                head_last_d = skid_last_q;
                if (push) begin
                    skid_data_d = map_data;
                    skid_user_d = I_tuser;
                    skid_last_d = I_tlast;
                end else begin
                    skid_vld_d = 1'b0;
                end
            end else if (push) begin
                head_data_d = map_data;
                head_user_d = I_tuser;
                head_last_d = I_tlast;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_data_d = map_data;
                head_user_d = I_tuser;
                head_last_d = I_tlast;
                head_vld_d  = 1'b1;
            end else begin
                skid_data_d = map_data;
                skid_user_d = I_tuser;
                skid_last_d = I_tlast;
                skid_vld_d  = 1'b1;
            end
        end
        rdy_d = ~(head_vld_d & skid_vld_d);
    end

    // Line-length check. cnt_q is the index the next beat will take; a
    // start-of-frame beat restarts the line as index 0, and the last legal
    // index is LINE_BEATS-1 whether or not it carries I_tlast.
    always_comb begin
        idx    = I_tuser ? '0 : cnt_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        mode_d = mode_q;
        fcnt_d = fcnt_q;
        if (push) begin
            if (I_tlast) begin
                err_d = (idx != LAST_IDX);
                cnt_d = '0;
            end else if (idx == LAST_IDX) begin
                err_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = idx + 1'b1;
            end
            if (I_tuser) begin
                mode_d = I_mode;
                fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge I_clk) begin
        if (!I_rstn) begin
            head_data_q <= '0;
            head_user_q <= 1'b0;
            head_last_q <= 1'b0;
            head_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_user_q <= 1'b0;
            skid_last_q <= 1'b0;
            skid_vld_q  <= 1'b0;
            rdy_q       <= 1'b0;
            mode_q      <= 2'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            fcnt_q      <= 16'd0;
        end else begin
            head_data_q <= head_data_d;
            head_user_q <= head_user_d;
            head_last_q <= head_last_d;
            head_vld_q  <= head_vld_d;
            skid_data_q <= skid_data_d;
            skid_user_q <= skid_user_d;
            skid_last_q <= skid_last_d;
            skid_vld_q  <= skid_vld_d;
            rdy_q       <= rdy_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fcnt_q      <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_data_unpad_axis.sv
// Randomised and directed bench for data_unpad_axis against a queue model.
module tb_data_unpad_axis;

    localparam int LANES      = 4;
    localparam int PIX_IN_W   = 32;
    localparam int PIX_OUT_W  = 24;
    localparam int LINE_BEATS = 480;
    localparam int IW         = LANES * PIX_IN_W;
    localparam int OW         = LANES * PIX_OUT_W;
    localparam int NB         = PIX_OUT_W / 8;

    logic            I_clk = 1'b0;
    logic            I_rstn = 1'b0;
    logic [1:0]      I_mode = 2'd0;
    logic [IW-1:0]   I_tdata = '0;
    logic            I_tvalid = 1'b0;
    logic            I_tuser = 1'b0;
    logic            I_tlast = 1'b0;
    logic            I_tready = 1'b0;
    logic            O_tready;
    logic [OW-1:0]   O_tdata;
    logic            O_tvalid;
    logic            O_tuser;
    logic            O_tlast;
    logic            O_err_len;
    logic [15:0]     O_frame_cnt;

    data_unpad_axis #(
        .LANES      (LANES),
        .PIX_IN_W   (PIX_IN_W),
        .PIX_OUT_W  (PIX_OUT_W),
        .LINE_BEATS (LINE_BEATS)
    ) dut (
        .I_clk       (I_clk),
        .I_rstn      (I_rstn),
        .I_mode      (I_mode),
        .I_tdata     (I_tdata),
        .I_tvalid    (I_tvalid),
        .I_tuser     (I_tuser),
        .I_tlast     (I_tlast),
        .O_tready    (O_tready),
        .O_tdata     (O_tdata),
        .O_tvalid    (O_tvalid),
        .O_tuser     (O_tuser),
        .O_tlast     (O_tlast),
        .I_tready    (I_tready),
        .O_err_len   (O_err_len),
        .O_frame_cnt (O_frame_cnt)
    );

    always #5 I_clk = ~I_clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    int          n_vec = 0;
    int          n_err = 0;
    beat_t       q[$];
    int          pos = 0;
    logic [1:0]  mmode = 2'd0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_fcnt = 16'd0;
    logic        exp_rdy = 1'b0;
    int          err_seen = 0;
    bit          lit_on = 0;
    logic [OW-1:0] lit_exp = '0;
    bit          fc_on = 0;
    logic [15:0] fc_exp = 16'd0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel arithmetic straight from the mode table.
    function automatic logic [OW-1:0] unpad(input logic [IW-1:0] d, input logic [1:0] m);
        logic [OW-1:0] r;
        logic [63:0]   p;
        logic [63:0]   kept;
        logic [63:0]   sw;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            p = 64'(d >> (k * PIX_IN_W)) & ((64'd1 << PIX_IN_W) - 64'd1);
            if (m[0]) kept = p >> (PIX_IN_W - PIX_OUT_W);
            else      kept = p & ((64'd1 << PIX_OUT_W) - 64'd1);
            if (m[1]) begin
                sw = 64'd0;
                for (int j = 0; j < NB; j++) begin
                    sw = sw | (((kept >> (8 * j)) & 64'hFF) << (8 * (NB - 1 - j)));
                end
                kept = sw;
            end
            r = r | (OW'(kept) << (k * PIX_OUT_W));
        end
        return r;
    endfunction

    // One clock: compare at the falling edge, then advance the model.
    task automatic step();
        beat_t      b;
        logic       acc;
        logic       pop;
        int         idx;
        logic [1:0] m;
        @(negedge I_clk);
        check("tready", O_tready, exp_rdy);
        check("tvalid", O_tvalid, q.size() > 0);
        if (q.size() > 0) begin
            check("tdata", O_tdata, q[0].data);
            check("tuser", O_tuser, q[0].user);
            check("tlast", O_tlast, q[0].last);
        end
        check("err_len", O_err_len, exp_err);
        check("frame_cnt", O_frame_cnt, exp_fcnt);
        if (O_err_len === 1'b1) err_seen++;
        if (lit_on) begin
            check("lit_tdata", O_tdata, lit_exp);
            lit_on = 0;
        end
        if (fc_on) begin
            check("lit_frame_cnt", O_frame_cnt, fc_exp);
            fc_on = 0;
        end
        if (!I_rstn) begin
            q.delete();
            pos = 0;
            mmode = 2'd0;
            exp_err = 1'b0;
            exp_fcnt = 16'd0;
            exp_rdy = 1'b0;
        end else begin
            acc = I_tvalid && exp_rdy;
            pop = (q.size() > 0) && I_tready;
            if (pop) b = q.pop_front();
            exp_err = 1'b0;
            if (acc) begin
                m = I_tuser ? I_mode : mmode;
                if (I_tuser) begin
                    mmode = I_mode;
                    exp_fcnt = exp_fcnt + 16'd1;
                end
                b.data = unpad(I_tdata, m);
                b.user = I_tuser;
                b.last = I_tlast;
                q.push_back(b);
                idx = I_tuser ? 0 : pos;
                if (I_tlast) begin
                    exp_err = (idx != LINE_BEATS - 1);
                    pos = 0;
                end else if (idx == LINE_BEATS - 1) begin
                    exp_err = 1'b1;
                    pos = 0;
                end else begin
                    pos = idx + 1;
                end
            end
            exp_rdy = q.size() < 2;
        end
        @(posedge I_clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic u, input logic l, input logic [1:0] m,
                        input logic [IW-1:0] d);
        I_tvalid = v;
        I_tuser  = u;
        I_tlast  = l;
        I_mode   = m;
        I_tdata  = d;
    endtask

    task automatic do_reset();
        I_rstn = 1'b0;
        repeat (3) step();
        check("rst_tdata", O_tdata, '0);
        check("rst_tuser", O_tuser, 1'b0);
        check("rst_tlast", O_tlast, 1'b0);
        check("rst_tready", O_tready, 1'b0);
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        I_rstn = 1'b1;
        step();
        check("tready_after_rst", O_tready, 1'b1);
    endtask

    localparam logic [IW-1:0] D_A = 128'hAA112233_BB445566_CC778899_DDAABBCC;
    localparam logic [IW-1:0] D_B = 128'h112233AA_445566BB_778899CC_AABBCCDD;

    initial begin
        int e0;
        I_tready = 1'b1;
        @(posedge I_clk);
        #1;
        do_reset();

        // Mode table examples
        beat(1'b1, 1'b1, 1'b0, 2'd0, D_A);
        step();
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        lit_on = 1; lit_exp = 96'h112233_445566_778899_AABBCC;
        fc_on = 1; fc_exp = 16'd1;
        step();
        beat(1'b1, 1'b1, 1'b0, 2'd2, D_A);
        step();
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        lit_on = 1; lit_exp = 96'h332211_665544_998877_CCBBAA;
        step();
        beat(1'b1, 1'b1, 1'b0, 2'd1, D_B);
        step();
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        lit_on = 1; lit_exp = 96'h112233_445566_778899_AABBCC;
        step();

        // Full-length line, then a short one
        e0 = err_seen;
        for (int i = 0; i < LINE_BEATS; i++) begin
            beat(1'b1, i == 0, i == LINE_BEATS - 1, 2'd0, {$urandom, $urandom, $urandom, $urandom});
            step();
        end
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        repeat (2) step();
        check("err_full_line", err_seen - e0, 0);
        e0 = err_seen;
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, i == 0, i == 9, 2'd0, {$urandom, $urandom, $urandom, $urandom});
            step();
        end
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        repeat (2) step();
        check("err_short_line", err_seen - e0, 1);

        // Downstream stall in a continuous stream
        for (int i = 0; i < 14; i++) begin
            I_tready = !(i >= 3 && i < 8);
            beat(1'b1, 1'b0, 1'b0, 2'd0, {$urandom, $urandom, $urandom, $urandom});
            step();
            if (i == 3) check("bp_tready_low", O_tready, 1'b0);
        end
        I_tready = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        repeat (3) step();

        // Reset mid-line with beats buffered
        beat(1'b1, 1'b1, 1'b0, 2'd3, D_A);
        step();
        I_tready = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 2'd0, D_A);
        step();
        step();
        do_reset();
        check("rst_tvalid", O_tvalid, 1'b0);
        I_tready = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 2'd3, D_A);
        step();
        beat(1'b1, 1'b1, 1'b0, 2'd0, D_A);
        lit_on = 1; lit_exp = 96'h112233_445566_778899_AABBCC;
        step();
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        fc_on = 1; fc_exp = 16'd1;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            I_tready = ($urandom_range(0, 9) < 7);
            beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom, $urandom, $urandom});
            step();
        end
        I_tready = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 2'd0, '0);
        repeat (4) step();
        check("drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_unpad_axis.md
DATA_UNPAD_AXIS -- requirements
Module: data_unpad_axis

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of pixel lanes per beat.
REQ-002 The block SHALL have parameter PIX_IN_W, default 32, giving the input pixel width in bits (padded).
REQ-003 The block SHALL have parameter PIX_OUT_W, default 24, giving the output pixel width in bits; it SHALL be a multiple of 8, no greater than PIX_IN_W.
REQ-004 The block SHALL have parameter LINE_BEATS, default 480, giving the expected beats per line.
REQ-005 I_clk  input  1  single clock for all logic.
REQ-006 I_rstn  input  1  reset, synchronous, active-low.
REQ-007 I_mode  input  2  repack mode, sampled per frame.
REQ-008 I_tdata  input  LANES*PIX_IN_W  padded pixel lanes, lane 0 in the LSBs.
REQ-009 I_tvalid, I_tuser, I_tlast  input  1 each  AXI-Stream valid, start-of-frame and end-of-line.
REQ-010 O_tready  output  1  input ready.
REQ-011 O_tdata  output  LANES*PIX_OUT_W  packed pixel lanes, lane 0 in the LSBs.
REQ-012 O_tvalid, O_tuser, O_tlast  output  1 each  output valid, start-of-frame and end-of-line.
REQ-013 I_tready  input  1  downstream ready.
REQ-014 O_err_len  output  1  one-cycle pulse on a line-length mismatch.
REQ-015 O_frame_cnt  output  16  count of accepted start-of-frame beats.

Function
REQ-016 A beat SHALL be accepted when I_tvalid and O_tready are both 1, and emitted when O_tvalid and I_tready are both 1.
REQ-017 Each lane k SHALL be mapped independently from input bits [k*PIX_IN_W +: PIX_IN_W] to output bits [k*PIX_OUT_W +: PIX_OUT_W], according to the active mode:
- Mode 0: keep the low PIX_OUT_W bits (drop the MSB pad).
- Mode 1: keep the high PIX_OUT_W bits (drop the LSB pad).
- Mode 2: as mode 0, then reverse the byte order of the kept pixel (R/B swap for 24-bit).
- Mode 3: as mode 1, then reverse the byte order of the kept pixel.
REQ-018 The active mode SHALL be loaded from I_mode on every accepted beat with I_tuser=1, and that beat SHALL itself use the newly loaded mode; it SHALL hold until the next such beat.
REQ-019 The datapath SHALL be a 2-entry skid buffer giving 1-cycle latency from acceptance to O_tvalid, with 1 beat/cycle sustained throughput.
REQ-020 O_tready SHALL depend only on registered state and SHALL be 0 only when both skid entries are occupied.
REQ-021 While O_tvalid=1 and I_tready=0, O_tdata, O_tuser and O_tlast SHALL remain stable.
REQ-022 O_tuser and O_tlast SHALL travel with their beat unchanged.
REQ-023 A beat counter SHALL increment on every accepted beat and clear on any accepted beat with I_tlast=1 or I_tuser=1; I_tlast takes priority over I_tuser when both are 1.
REQ-024 When an accepted I_tlast beat arrives with the counter not equal to LINE_BEATS-1, O_err_len SHALL pulse high for exactly one cycle, 1 cycle after acceptance.
REQ-025 If the counter reaches LINE_BEATS-1 and a further beat without I_tlast is accepted, O_err_len SHALL pulse and the counter SHALL wrap to 0.
REQ-026 O_frame_cnt SHALL increment by 1 on each accepted I_tuser=1 beat, wrapping from 0xFFFF to 0x0000.
REQ-027 The block SHALL never drop, duplicate or reorder beats.

Reset
REQ-028 While I_rstn=0 at a rising edge of I_clk, the block SHALL clear both skid entries, the beat counter and O_frame_cnt, and set the active mode to 0.
REQ-029 The reset values SHALL be: O_tvalid=0, O_tdata=0, O_tuser=0, O_tlast=0, O_err_len=0, O_frame_cnt=0.
REQ-030 O_tready SHALL be 0 during reset and SHALL be 1 in the first cycle after I_rstn returns to 1.
REQ-031 A reset asserted mid-line SHALL discard all buffered beats without emitting them and without pulsing O_err_len.

Verification
REQ-032 Mode 0 with defaults: beat I_tdata=0xAA112233_BB445566_CC778899_DDAABBCC with I_tuser=1 -> O_tdata=0x112233_445566_778899_AABBCC one cycle later, O_tuser=1, O_frame_cnt=1.
REQ-033 Mode 2 with the same input -> O_tdata=0x332211_665544_998877_CCBBAA.
REQ-034 Mode 1 with I_tdata=0x112233AA_445566BB_778899CC_AABBCCDD -> O_tdata=0x112233_445566_778899_AABBCC.
REQ-035 A line of 480 beats with I_tlast on beat 479 -> no O_err_len; a line of 10 beats with I_tlast on beat 9 -> a single O_err_len pulse.
REQ-036 Backpressure: hold I_tready=0 for 5 cycles during a continuous stream -> O_tready falls after 2 buffered beats, O_tdata stays stable, and all beats exit in order with none lost.
REQ-037 Reset mid-line after 3 beats, then a new frame -> no stale beats are emitted, O_frame_cnt=1 after the first new I_tuser beat, and the mode reverts to 0 until reloaded.
